data_memory_responder: RTL
==========================

# data_memory_responder

Main-memory responder for the data cache's miss traffic. It serves line refills (memory to cache) and line writebacks (cache to memory) over a request/burst handshake, with a programmable access latency. It sits below the data cache, on the opposite end of the cache's memory port. It holds a word-addressed backing store and returns refill words critical-word-first.

## Interface
Parameters:
- MEMORY_DEPTH_WORDS, 1024: backing store size in 32-bit words; power of two.
- LINE_WORDS, 4: words per cache line; power of two, ≥2.
- ACCESS_LATENCY, 4: cycles between accept and first data beat; ≥1.
- HIGH, 1'b1: logic high.
- LOW, 1'b0: logic low.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- MEM_REQUEST  input  1  request valid; sampled only in IDLE.
- MEM_WRITE  input  1  1 = writeback, 0 = refill; sampled with MEM_REQUEST.
- MEM_ADDRESS  input  32  byte address. Refill uses word offset as critical word. Writeback ignores the low log2(LINE_WORDS)+2 bits.
- MEM_WRITE_DATA  input  32  writeback word for current beat.
- MEM_WRITE_VALID  input  1  writeback word present.
- MEM_ACCEPT  output  1  one-cycle pulse, request latched.
- MEM_BUSY  output  1  high whenever state ≠ IDLE.
- MEM_READ_DATA  output  32  refill word; registered.
- MEM_READ_VALID  output  1  refill beat valid; registered.
- MEM_WRITE_READY  output  1  responder accepts a writeback beat this cycle.
- MEM_DONE  output  1  one-cycle pulse, transaction complete.

## Operation
- States: IDLE, LATENCY, READ_BURST, WRITE_BURST, DONE.
- IDLE with MEM_REQUEST=1:
  - Latch line base = word index with low log2(LINE_WORDS) bits cleared.
  - Latch start offset: the address word offset for refill, 0 for writeback.
  - Latch direction and load the latency counter with ACCESS_LATENCY-1.
  - Go to LATENCY; MEM_ACCEPT is high for the first LATENCY cycle.
- LATENCY: when the counter is 0, go to READ_BURST or WRITE_BURST by the latched direction; otherwise decrement.
- READ_BURST:
  - One beat per cycle, no backpressure, for exactly LINE_WORDS beats.
  - Word offset = (start + beat) mod LINE_WORDS, wrapping within the line.
  - After the last beat, go to DONE.
- WRITE_BURST:
  - MEM_WRITE_READY is high.
  - A beat transfers when MEM_WRITE_VALID and MEM_WRITE_READY are both high. The word goes to line base + beat, and beat increments.
  - Cycles with VALID low are stalls with no write.
  - After LINE_WORDS transfers, go to DONE.
- DONE: MEM_DONE=1 for one cycle, then IDLE.
- Address mapping: word index = MEM_ADDRESS[31:2] mod MEMORY_DEPTH_WORDS. Out-of-range addresses wrap silently with no error.
- MEM_REQUEST outside IDLE is ignored. It is not queued, and the initiator must hold or re-issue it.
- MEM_WRITE_VALID outside WRITE_BURST is ignored, with no memory write.
- Backing store contents are not cleared by RST.

## Timing
- Cycle 0 is the IDLE cycle in which MEM_REQUEST is sampled high; L = ACCESS_LATENCY, N = LINE_WORDS.
- MEM_ACCEPT is high in cycle 1 only. LATENCY occupies cycles 1..L.
- Refill:
  - MEM_READ_VALID is high in cycles L+1..L+N, contiguous.
  - MEM_READ_DATA is valid only with MEM_READ_VALID and holds 0 otherwise.
  - MEM_DONE is in cycle L+N+1.
- Writeback:
  - MEM_WRITE_READY rises in cycle L+1 and stays high until the cycle of the N-th transfer, inclusive.
  - MEM_DONE is in the cycle after the N-th transfer.
- MEM_BUSY is high from cycle 1 through the DONE cycle. The earliest next request is sampled in the cycle after MEM_DONE.
- Reset values: all outputs 0, state IDLE, counter 0, beat 0.
- Reset mid-transaction: the next cycle is IDLE with all outputs 0. Already-written writeback words persist. Remaining refill beats are dropped.
- RST takes priority over a simultaneous MEM_REQUEST; that request is not accepted.
- A writeback write and a refill read to the same word never coexist, since there is one transaction at a time.

## Test plan
- Reset: RST high 2 cycles with random inputs -> all outputs 0, MEM_BUSY 0, no MEM_ACCEPT.
- Writeback 0x100, words 0xA0..0xA3, VALID held high, L=4, N=4 -> MEM_ACCEPT cycle 1; MEM_WRITE_READY cycles 5–8; MEM_DONE cycle 9; MEM_BUSY cycles 1–9.
- Refill 0x108 after the previous test -> MEM_READ_VALID cycles 5–8 with data 0xA2, 0xA3, 0xA0, 0xA1; MEM_DONE cycle 9.
- Writeback 0x200 with VALID toggling 1,0,1,0,... -> exactly 4 writes at beats 0–3. A refill of 0x200 then returns them in order.
- Refill of 0x1000 with depth 1024, plus a second MEM_REQUEST pulsed in cycle 3 -> returns the words stored at 0x000. The second request is ignored: no second MEM_ACCEPT.
- RST asserted during the second refill beat -> MEM_READ_VALID 0 from the next cycle, MEM_DONE never pulses. A fresh refill afterwards gets MEM_ACCEPT at cycle 1 with correct data.

Source files
------------

// File: rtl/data_memory_responder.sv
// Main-memory responder for data-cache miss traffic: critical-word-first line
// refills and in-order line writebacks behind a programmable access latency.
module data_memory_responder #(
  parameter int unsigned MEMORY_DEPTH_WORDS = 1024,
  parameter int unsigned LINE_WORDS         = 4,
  parameter int unsigned ACCESS_LATENCY     = 4,
  parameter logic        HIGH               = 1'b1,
  parameter logic        LOW                = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_REQUEST,
  input  logic        MEM_WRITE,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WRITE_DATA,
  input  logic        MEM_WRITE_VALID,
  output logic        MEM_ACCEPT,
  output logic        MEM_BUSY,
  output logic [31:0] MEM_READ_DATA,
  output logic        MEM_READ_VALID,
  output logic        MEM_WRITE_READY,
  output logic        MEM_DONE
);

  localparam int unsigned AW = $clog2(MEMORY_DEPTH_WORDS);
  localparam int unsigned OW = $clog2(LINE_WORDS);
  localparam int unsigned LW = AW - OW;
  localparam int unsigned BW = OW + 1;
  localparam int unsigned CW = $clog2(ACCESS_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE,
    LATENCY,
    READ_BURST,
    WRITE_BURST,
    DONE
  } state_t;

  state_t        state;
  logic [LW-1:0] line_q;
  logic [OW-1:0] start_q;
  logic          write_q;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] beat_q;

  logic [31:0]   mem [MEMORY_DEPTH_WORDS];

  logic [AW-1:0] addr_word;
  logic [OW-1:0] rd_off;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          unused_addr;

  // Word index wraps silently modulo the store depth.
  assign addr_word   = MEM_ADDRESS[AW+1:2];
  assign unused_addr = ^{MEM_ADDRESS[31:AW+2], MEM_ADDRESS[1:0]};

  // First refill beat is issued from LATENCY, later ones wrap within the line.
  assign rd_off  = (state == LATENCY) ? start_q : OW'(start_q + beat_q[OW-1:0]);
  assign rd_addr = {line_q, rd_off};
  assign wr_addr = {line_q, beat_q[OW-1:0]};
  assign wr_en   = (state == WRITE_BURST) && MEM_WRITE_VALID && !RST;

  // Backing store is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= MEM_WRITE_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      line_q          <= '0;
      start_q         <= '0;
      write_q         <= LOW;
      cnt_q           <= '0;
      beat_q          <= '0;
      MEM_ACCEPT      <= LOW;
      MEM_BUSY        <= LOW;
      MEM_READ_DATA   <= '0;
      MEM_READ_VALID  <= LOW;
      MEM_WRITE_READY <= LOW;
      MEM_DONE        <= LOW;
    end else begin
      MEM_ACCEPT     <= LOW;
      MEM_DONE       <= LOW;
      MEM_READ_VALID <= LOW;
      MEM_READ_DATA  <= '0;
      case (state)
        IDLE: begin
          if (MEM_REQUEST) begin
            line_q     <= addr_word[AW-1:OW];
            start_q    <= MEM_WRITE ? '0 : addr_word[OW-1:0];
            write_q    <= MEM_WRITE;
            cnt_q      <= CW'(ACCESS_LATENCY - 1);
            beat_q     <= '0;
            MEM_ACCEPT <= HIGH;
            MEM_BUSY   <= HIGH;
            state      <= LATENCY;
          end
        end
        LATENCY: begin
          if (cnt_q == '0) begin
            if (write_q) begin
              state           <= WRITE_BURST;
              MEM_WRITE_READY <= HIGH;
            end else begin
              state          <= READ_BURST;
              MEM_READ_VALID <= HIGH;
              MEM_READ_DATA  <= mem[rd_addr];
              beat_q         <= BW'(1);
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        READ_BURST: begin
          // beat_q counts beats already presented on the bus.
          if (beat_q == BW'(LINE_WORDS)) begin
            state    <= DONE;
            MEM_DONE <= HIGH;
          end else begin
            MEM_READ_VALID <= HIGH;
            MEM_READ_DATA  <= mem[rd_addr];
            beat_q         <= beat_q + BW'(1);
          end
        end
        WRITE_BURST: begin
          if (MEM_WRITE_VALID) begin
            beat_q <= beat_q + BW'(1);
            if (beat_q == BW'(LINE_WORDS - 1)) begin
              state           <= DONE;
              MEM_WRITE_READY <= LOW;
              MEM_DONE        <= HIGH;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          MEM_BUSY <= LOW;
          beat_q   <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
